// File: rtl/key_pulse_gen.sv
// Debounced one-shot pulse generator for four active-low push-buttons.
// Define KEY_PULSE_LOCKOUT_EN to allow only one pulse at a time, and to block a pulse while another key is held.
module key_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic [3:0] KEY,
  output logic       P0_pulse,
  output logic       P1_pulse,
  output logic       P2_pulse,
  output logic       P3_pulse,
  output logic [3:0] key_held
);
  localparam int NUM_KEYS = 4;

  logic [NUM_KEYS-1:0] qual;
  logic [NUM_KEYS-1:0] grant;
  logic [NUM_KEYS-1:0] pulse_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk    (clk),
      .RESET_N(RESET_N),
      .key_n  (KEY[i]),
      .qual   (qual[i]),
      .held   (key_held[i])
    );
  end

`ifdef KEY_PULSE_LOCKOUT_EN
  logic [NUM_KEYS-1:0] elig;

  // A held key blocks every other key's pulse; same-edge ties go 3 > 0 > 1 > 2.
  always_comb begin
    elig  = '0;
    grant = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      elig[k] = qual[k] & ~|(key_held & ~(NUM_KEYS'(1) << k));
    if (elig[3])      grant = 4'b1000;
    else if (elig[0]) grant = 4'b0001;
    else if (elig[1]) grant = 4'b0010;
    else if (elig[2]) grant = 4'b0100;
  end
`else
  assign grant = qual;
`endif

  always_ff @(posedge clk) begin
    if (!RESET_N) pulse_q <= '0;
    else          pulse_q <= grant;
  end

  assign P0_pulse = pulse_q[0];
  assign P1_pulse = pulse_q[1];
  assign P2_pulse = pulse_q[2];
  assign P3_pulse = pulse_q[3];
endmodule

// One key: two-flop synchroniser plus press/release debounce FSM.
module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic RESET_N,
  input  logic key_n,
  output logic qual,
  output logic held
);
  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             s;

  always_ff @(posedge clk) begin
    if (!RESET_N) sync_q <= '0;
    else          sync_q <= {sync_q[0], ~key_n};
  end

  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt counts consecutive samples that disagree with the debounced level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    qual = (state_q == PRESS_WAIT) && s && (cnt_q == CNT_MAX);
    held = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  end
endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: directed timing scenarios plus random key activity vs. a run-length model.
module tb_key_pulse_gen;
  localparam int DC = 4;

  logic       clk;
  logic       RESET_N;
  logic [3:0] KEY;
  logic       P0_pulse, P1_pulse, P2_pulse, P3_pulse;
  logic [3:0] key_held;
  logic [3:0] pulses;

  int checks = 0;
  int errors = 0;

  key_pulse_gen #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk     (clk),
    .RESET_N (RESET_N),
    .KEY     (KEY),
    .P0_pulse(P0_pulse),
    .P1_pulse(P1_pulse),
    .P2_pulse(P2_pulse),
    .P3_pulse(P3_pulse),
    .key_held(key_held)
  );

  assign pulses = {P3_pulse, P2_pulse, P1_pulse, P0_pulse};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a key's level flips once DC consecutive synced samples disagree with it.
  logic [3:0] m_s1, m_s2, m_lvl, m_pulse;
  int         m_run [4];

  function automatic logic [3:0] m_fresh();
    m_fresh = '0;
    for (int j = 0; j < 4; j++)
      m_fresh[j] = m_s2[j] && !m_lvl[j] && (m_run[j] + 1 == DC);
  endfunction

  function automatic logic [3:0] m_arb(input logic [3:0] q, input logic [3:0] lvl);
`ifdef KEY_PULSE_LOCKOUT_EN
    int ord [4] = '{3, 0, 1, 2};
    m_arb = '0;
    if (lvl == 4'b0)
      for (int j = 0; j < 4; j++)
        if (q[ord[j]] && m_arb == 4'b0) m_arb[ord[j]] = 1'b1;
`else
    m_arb = q | (lvl & 4'b0);
`endif
  endfunction

  always @(posedge clk) begin
    if (!RESET_N) begin
      m_s1    <= '0;
      m_s2    <= '0;
      m_lvl   <= '0;
      m_pulse <= '0;
      for (int i = 0; i < 4; i++) m_run[i] <= 0;
    end else begin
      m_s1    <= ~KEY;
      m_s2    <= m_s1;
      m_pulse <= m_arb(m_fresh(), m_lvl);
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] == m_lvl[i]) m_run[i] <= 0;
        else if (m_run[i] + 1 == DC) begin
          m_run[i] <= 0;
          m_lvl[i] <= ~m_lvl[i];
        end else m_run[i] <= m_run[i] + 1;
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    KEY     = 4'b0000;
    for (int e = 0; e < DC + 4; e++) begin
      @(negedge clk);
      checks++;
      if ({pulses, key_held} !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold e=%0d pulses=%b held=%b want 0000/0000", e, pulses, key_held);
      end
    end
    RESET_N = 1'b1;
    KEY     = 4'hF;
    settle(DC + 4);
    checks++;
    if (pulses !== m_pulse || key_held !== m_lvl || key_held !== 4'b0) begin
      errors++;
      $display("FAIL reset_release pulses=%b held=%b want %b/0000", pulses, key_held, m_pulse);
    end
  endtask

  task automatic test_single_press();
    logic [3:0] ep, eh;
    for (int e = 0; e <= 14; e++) begin
      KEY = 4'b1110;
      @(negedge clk);
      ep = (e == DC + 1) ? 4'b0001 : 4'b0000;
      eh = (e >= DC + 1) ? 4'b0001 : 4'b0000;
      checks++;
      if (pulses !== ep || key_held !== eh || pulses !== m_pulse || key_held !== m_lvl) begin
        errors++;
        $display("FAIL single_press e=%0d pulses=%b held=%b want %b/%b", e, pulses, key_held, ep, eh);
      end
    end
    KEY = 4'hF;
    settle(DC + 6);
  endtask

  task automatic test_press_bounce();
    logic [3:0] ep;
    for (int e = 0; e <= 14; e++) begin
      KEY = (e == 2) ? 4'hF : 4'b1110;
      @(negedge clk);
      ep = (e == 3 + DC + 1) ? 4'b0001 : 4'b0000;
      checks++;
      if (pulses !== ep || pulses !== m_pulse || key_held !== m_lvl) begin
        errors++;
        $display("FAIL press_bounce e=%0d pulses=%b held=%b want %b/%b", e, pulses, key_held, ep, m_lvl);
      end
    end
    KEY = 4'hF;
    settle(DC + 6);
  endtask

  task automatic test_release_bounce();
    logic [3:0] ep, eh;
    for (int e = 0; e <= 22; e++) begin
      KEY = (e < 10 || e == 11) ? 4'b1101 : 4'hF;
      @(negedge clk);
      ep = (e == DC + 1) ? 4'b0010 : 4'b0000;
      eh = (e >= DC + 1 && e < 12 + DC + 1) ? 4'b0010 : 4'b0000;
      checks++;
      if (pulses !== ep || key_held !== eh || pulses !== m_pulse || key_held !== m_lvl) begin
        errors++;
        $display("FAIL release_bounce e=%0d pulses=%b held=%b want %b/%b", e, pulses, key_held, ep, eh);
      end
    end
    settle(4);
  endtask

  task automatic test_reset_mid_count();
    logic [3:0] ep, eh;
    for (int e = 0; e <= 14; e++) begin
      KEY     = 4'b0111;
      RESET_N = (e == DC + 1) ? 1'b0 : 1'b1;
      @(negedge clk);
      ep = (e == 2 * DC + 3) ? 4'b1000 : 4'b0000;
      eh = (e >= 2 * DC + 3) ? 4'b1000 : 4'b0000;
      checks++;
      if (pulses !== ep || key_held !== eh || pulses !== m_pulse || key_held !== m_lvl) begin
        errors++;
        $display("FAIL reset_mid_count e=%0d pulses=%b held=%b want %b/%b", e, pulses, key_held, ep, eh);
      end
    end
    RESET_N = 1'b1;
    KEY     = 4'hF;
    settle(DC + 6);
  endtask

  task automatic test_simultaneous();
    logic [3:0] ep, eh;
    for (int e = 0; e <= 10; e++) begin
      KEY = 4'b1100;
      @(negedge clk);
`ifdef KEY_PULSE_LOCKOUT_EN
      ep = (e == DC + 1) ? 4'b0001 : 4'b0000;
`else
      ep = (e == DC + 1) ? 4'b0011 : 4'b0000;
`endif
      eh = (e >= DC + 1) ? 4'b0011 : 4'b0000;
      checks++;
      if (pulses !== ep || key_held !== eh || pulses !== m_pulse || key_held !== m_lvl) begin
        errors++;
        $display("FAIL simultaneous e=%0d pulses=%b held=%b want %b/%b", e, pulses, key_held, ep, eh);
      end
    end
    KEY = 4'hF;
    settle(DC + 6);
  endtask

  task automatic test_lockout();
    logic [3:0] ep, eh;
    for (int e = 0; e <= 22; e++) begin
      KEY = (e < 10) ? 4'b1110 : 4'b0110;
      @(negedge clk);
`ifdef KEY_PULSE_LOCKOUT_EN
      ep = (e == DC + 1) ? 4'b0001 : 4'b0000;
`else
      ep = (e == DC + 1) ? 4'b0001 : (e == 10 + DC + 1) ? 4'b1000 : 4'b0000;
`endif
      eh = {e >= 10 + DC + 1, 2'b00, e >= DC + 1};
      checks++;
      if (pulses !== ep || key_held !== eh || pulses !== m_pulse || key_held !== m_lvl) begin
        errors++;
        $display("FAIL lockout_held e=%0d pulses=%b held=%b want %b/%b", e, pulses, key_held, ep, eh);
      end
    end
    KEY = 4'hF;
    settle(DC + 6);
    for (int e = 0; e <= 8; e++) begin
      KEY = 4'b0111;
      @(negedge clk);
      ep = (e == DC + 1) ? 4'b1000 : 4'b0000;
      checks++;
      if (pulses !== ep || pulses !== m_pulse || key_held !== m_lvl) begin
        errors++;
        $display("FAIL lockout_alone e=%0d pulses=%b held=%b want %b/%b", e, pulses, key_held, ep, m_lvl);
      end
    end
    KEY = 4'hF;
    settle(DC + 6);
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        KEY  = 4'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      RESET_N = ($urandom_range(0, 99) != 0);
      @(negedge clk);
      checks++;
      if (pulses !== m_pulse || key_held !== m_lvl) begin
        errors++;
        $display("FAIL random c=%0d pulses=%b held=%b want %b/%b", c, pulses, key_held, m_pulse, m_lvl);
      end
`ifdef KEY_PULSE_LOCKOUT_EN
      checks++;
      if (!$onehot0(pulses)) begin
        errors++;
        $display("FAIL random_onehot c=%0d pulses=%b want at most one bit", c, pulses);
      end
`endif
    end
    RESET_N = 1'b1;
    KEY     = 4'hF;
    settle(DC + 6);
  endtask

  initial begin
    RESET_N = 1'b0;
    KEY     = 4'hF;
    test_reset();
    test_single_press();
    test_press_bounce();
    test_release_bounce();
    test_reset_mid_count();
    test_simultaneous();
    test_lockout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
